// File: rtl/accel_muldiv.sv
// Accelerator-bus responder: iterative 16-cycle unsigned multiply / restoring divide.
// Command, A and B arrive as writes; two result words are popped as reads.
module accel_muldiv #(
  parameter logic [3:0] ACCEL_ID  = 4'd1,
  parameter int         REG_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           accel_id,
  output logic                 accel_can_read,
  output logic                 accel_can_write,
  input  logic                 accel_read_enable,
  output logic [REG_WIDTH-1:0] accel_read_data,
  input  logic                 accel_write_enable,
  input  logic [REG_WIDTH-1:0] accel_write_data
);
  localparam int W  = REG_WIDTH;
  localparam int CW = $clog2(REG_WIDTH);

  typedef enum logic [2:0] {IDLE, GET_A, GET_B, BUSY, RES_LO, RES_HI} state_t;

  state_t          state;
  logic            cmd_div;
  logic [W-1:0]    op_a, op_b;
  logic [CW-1:0]   cnt;
  // MUL: {partial_hi, multiplier_lo}; DIV: {remainder, quotient/dividend}
  logic [2*W-1:0]  acc;
  logic [2*W-1:0]  acc_nxt;
  logic [W:0]      mul_sum, div_shift, div_diff;
  logic            sel, wr_ok, rd_ok, wr_acc, rd_acc;

  assign sel    = (accel_id == ACCEL_ID);
  assign wr_ok  = (state == IDLE) || (state == GET_A) || (state == GET_B);
  assign rd_ok  = (state == RES_LO) || (state == RES_HI);
  assign wr_acc = accel_write_enable && sel && wr_ok;
  assign rd_acc = accel_read_enable && sel && rd_ok;

  assign accel_can_write = sel && wr_ok;
  assign accel_can_read  = sel && rd_ok;
  assign accel_read_data = !(sel && rd_ok)  ? '0 :
                           (state == RES_HI) ? acc[2*W-1:W] : acc[W-1:0];

  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, op_b} : '0);
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_diff  = div_shift - {1'b0, op_b};
    acc_nxt   = {mul_sum, acc[W-1:1]};
    if (cmd_div) begin
      // Borrow clear means the trial subtraction fits: keep it, quotient bit 1.
      if (!div_diff[W]) acc_nxt = {div_diff[W-1:0], acc[W-2:0], 1'b1};
      else              acc_nxt = {div_shift[W-1:0], acc[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cmd_div <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      cnt     <= '0;
      acc     <= '0;
    end else begin
      case (state)
        IDLE: if (wr_acc) begin
          cmd_div <= accel_write_data[0];
          state   <= GET_A;
        end
        GET_A: if (wr_acc) begin
          op_a  <= accel_write_data;
          state <= GET_B;
        end
        GET_B: if (wr_acc) begin
          op_b  <= accel_write_data;
          acc   <= {{W{1'b0}}, op_a};
          cnt   <= '0;
          state <= BUSY;
        end
        BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(REG_WIDTH - 1)) state <= RES_LO;
        end
        RES_LO: if (rd_acc) state <= RES_HI;
        RES_HI: if (rd_acc) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accel_muldiv.sv
// Directed bench for accel_muldiv: expected result words queued at stimulus time, checked on read.
module tb_accel_muldiv;
  localparam logic [3:0] ID    = 4'd1;
  localparam logic [3:0] OTHER = 4'd6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  accel_id = OTHER;
  logic        can_read, can_write;
  logic        read_enable = 1'b0;
  logic [15:0] read_data;
  logic        write_enable = 1'b0;
  logic [15:0] write_data = '0;

  int tests = 0;
  int fails = 0;
  logic [15:0] sb[$];

  accel_muldiv #(.ACCEL_ID(ID), .REG_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .accel_id(accel_id),
    .accel_can_read(can_read), .accel_can_write(can_write),
    .accel_read_enable(read_enable), .accel_read_data(read_data),
    .accel_write_enable(write_enable), .accel_write_data(write_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model, independent of the iterative hardware algorithm.
  task automatic push_model(input logic div, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    if (!div) begin
      p = {16'h0, a} * {16'h0, b};
      sb.push_back(p[15:0]); sb.push_back(p[31:16]);
    end else if (b == 16'h0) begin
      sb.push_back(16'hFFFF); sb.push_back(a);
    end else begin
      sb.push_back(a / b); sb.push_back(a % b);
    end
  endtask

  task automatic wr(input logic [15:0] d);
    @(negedge clk);
    accel_id = ID; write_enable = 1'b1; write_data = d;
    #1 check("can_write_before_wr", can_write, 1);
    @(posedge clk);
    #1 write_enable = 1'b0;
  endtask

  task automatic rd(input string tag);
    logic [15:0] exp;
    @(negedge clk);
    accel_id = ID; read_enable = 1'b1;
    #1;
    check({tag, "_can_read"}, can_read, 1);
    if (sb.size() == 0) check({tag, "_sb_empty"}, 1, 0);
    else begin
      exp = sb.pop_front();
      check(tag, read_data, exp);
    end
    @(posedge clk);
    #1 read_enable = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    while (!can_read && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_wait"}, can_read, 1);
  endtask

  task automatic run_op(input string tag, input logic div, input logic [15:0] a, input logic [15:0] b);
    push_model(div, a, b);
    wr({15'h0, div}); wr(a); wr(b);
    wait_result(tag);
    rd({tag, "_lo"}); rd({tag, "_hi"});
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk); accel_id = ID; #1;
    check({tag, "_idle_cw"}, can_write, 1);
    check({tag, "_idle_cr"}, can_read, 0);
  endtask

  initial begin
    // Reset state, selected and not
    accel_id = ID; #2;
    check("rst_sel_cw", can_write, 1);
    check("rst_sel_cr", can_read, 0);
    check("rst_sel_rd", read_data, 0);
    accel_id = OTHER; #1;
    check("rst_nsel_all", {can_write, can_read, read_data}, 0);
    @(negedge clk); rst = 1'b1;

    // First MUL with exact latency check
    sb.push_back(16'h0060); sb.push_back(16'h0626);
    wr(16'h0000); wr(16'h1234); wr(16'h5678);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i < 16) check($sformatf("lat_busy_%0d", i), {can_read, can_write}, 2'b00);
      else        check("lat_ready_16", can_read, 1);
    end
    rd("mul1_lo"); rd("mul1_hi");
    check_idle("mul1");

    // Deselected: both enables toggling, outputs stay 0, state stays IDLE
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      accel_id = OTHER; write_enable = i[0]; read_enable = ~i[0]; write_data = 16'hBEEF;
      #1 check($sformatf("nsel_out_%0d", i), {can_write, can_read, read_data}, 0);
    end
    @(negedge clk); write_enable = 1'b0; read_enable = 1'b0;
    check_idle("nsel");

    sb.push_back(16'h0001); sb.push_back(16'hFFFE);
    wr(16'h0000); wr(16'hFFFF); wr(16'hFFFF);
    wait_result("mulmax"); rd("mulmax_lo"); rd("mulmax_hi");

    // DIV 1000/7 with other-accelerator traffic between operand writes
    sb.push_back(16'h008E); sb.push_back(16'h0006);
    wr(16'hFFF1);
    @(negedge clk); accel_id = OTHER; write_enable = 1'b1; write_data = 16'hBEEF;
    @(negedge clk); write_enable = 1'b0;
    wr(16'd1000);
    @(negedge clk); accel_id = OTHER; write_enable = 1'b1; read_enable = 1'b1;
    @(negedge clk); write_enable = 1'b0; read_enable = 1'b0;
    wr(16'd7);
    wait_result("div7"); rd("div7_lo"); rd("div7_hi");

    sb.push_back(16'hFFFF); sb.push_back(16'h1234);
    wr(16'h0001); wr(16'h1234); wr(16'h0000);
    wait_result("div0"); rd("div0_lo"); rd("div0_hi");
    sb.push_back(16'h0000); sb.push_back(16'h0005);
    wr(16'h0001); wr(16'd5); wr(16'd9);
    wait_result("div59"); rd("div59_lo"); rd("div59_hi");

    // Ignored enables: read during BUSY, write during RES_LO
    push_model(1'b0, 16'hABCD, 16'h0102);
    wr(16'h0000); wr(16'hABCD); wr(16'h0102);
    @(negedge clk); read_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("busy_rd_ign_%0d", i), {can_read, read_data}, 0);
      @(negedge clk);
    end
    read_enable = 1'b0;
    wait_result("ign");
    @(negedge clk); write_enable = 1'b1; write_data = 16'hBEEF;
    #1 check("res_cw0", can_write, 0);
    @(negedge clk); write_enable = 1'b0;
    rd("ign_lo"); rd("ign_hi");
    check_idle("ign");

    // Async reset mid-BUSY, no result survives
    wr(16'h0001); wr(16'hFFFF); wr(16'h0003);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_cw", can_write, 1);
    check("arst_cr", can_read, 0);
    check("arst_rd", read_data, 0);
    @(negedge clk); rst = 1'b1;
    check_idle("arst");
    sb.push_back(16'h000C); sb.push_back(16'h0000);
    wr(16'h0000); wr(16'd3); wr(16'd4);
    wait_result("m34"); rd("m34_lo"); rd("m34_hi");

    // A few random operations against the model
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("rnd%0d", i), i[0], 16'($urandom), 16'($urandom_range(0, 300)));
    end
    check_idle("end");
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
